// File: rtl/pipe_l1a_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ro_pkg
// Brief    : Shared constants, FSM state type and NSAMP clamp helper for the
//            per-group L1A readout slice.
// Revision : 1.0  initial release
// ============================================================================
package pipe_ro_pkg;

  localparam int NCH    = 16;            // channels per pipeline word
  localparam int ADC_W  = 12;            // bits per ADC sample
  localparam int WORD_W = NCH * ADC_W;   // 192-bit pipeline word
  localparam int CH_W   = 4;             // channel index width
  localparam int SMP_W  = 4;             // sample index width
  localparam int N_W    = 5;             // sample-count width (holds 1..16)

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  // Out-of-range requests (0 or above the buffer depth) fall back to a full
  // buffer's worth of samples rather than producing an empty event.
  function automatic logic [N_W-1:0] clamp_nsamp(input logic [N_W-1:0] nsamp,
                                                 input int max_samp);
    logic [N_W-1:0] w_max;
    w_max = N_W'(max_samp);
    if (nsamp == '0 || int'(nsamp) > max_samp) begin
      return w_max;
    end
    return nsamp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_l1a_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ro_if
// Brief    : Sample stream from the L1A readout to the DAQ formatter.
//            One 12-bit ADC sample per valid/ready transfer, tagged with its
//            channel and sample index and an end-of-event marker.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ro_if;
  import pipe_ro_pkg::*;

  logic [ADC_W-1:0] DOUT;
  logic [CH_W-1:0]  DOUT_CH;
  logic [SMP_W-1:0] DOUT_SMP;
  logic             DOUT_VLD;
  logic             DOUT_LAST;
  logic             DOUT_RDY;

  // Readout side drives the stream
  modport master (
    output DOUT,
    output DOUT_CH,
    output DOUT_SMP,
    output DOUT_VLD,
    output DOUT_LAST,
    input  DOUT_RDY
  );

  // Formatter side consumes the stream
  modport slave (
    input  DOUT,
    input  DOUT_CH,
    input  DOUT_SMP,
    input  DOUT_VLD,
    input  DOUT_LAST,
    output DOUT_RDY
  );

endinterface
`default_nettype wire

// File: rtl/pipe_l1a_readout_evt_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_evt_buf
// Brief    : Event buffer holding captured pipeline words. One synchronous
//            write port, one asynchronous read port. Contents are never
//            cleared; every event overwrites the slots it reads back.
// Revision : 1.0  initial release
// ============================================================================
module pipe_evt_buf
  import pipe_ro_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic              CLK,
  input  wire logic              WE,
  input  wire logic [AW-1:0]     WADDR,
  input  wire logic [WORD_W-1:0] WDATA,
  input  wire logic [AW-1:0]     RADDR,
  output logic      [WORD_W-1:0] RDATA
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Store one pipeline word per write strobe; no reset so the array maps to plain storage
  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[WADDR] <= WDATA;
    end
  end

  // Read is combinational so a word written in cycle k is visible from k+1
  assign RDATA = r_mem[RADDR];

endmodule
`default_nettype wire

// File: rtl/pipe_l1a_readout.sv
`default_nettype none
// ============================================================================
// Module   : pipe_l1a_readout
// Brief    : On L1A, capture NSAMP consecutive valid pipeline words into a
//            local buffer, then stream them out one 12-bit sample per
//            valid/ready transfer, channel-major (all samples of channel 0,
//            then channel 1, ...). Triggers arriving while busy are dropped
//            and counted.
// Revision : 1.0  initial release
// ============================================================================
module pipe_l1a_readout
  import pipe_ro_pkg::*;
#(
  parameter int MAX_SAMP = 16,
  parameter int MISS_W   = 8
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  input  wire logic [WORD_W-1:0] PIPOUT,
  input  wire logic              PIPE_VLD,
  input  wire logic              L1A,
  input  wire logic [N_W-1:0]    NSAMP,
  pipe_ro_if.master              dout_if,
  output logic                   BUSY,
  output logic                   L1A_MISS,
  output logic [MISS_W-1:0]      MISS_CNT,
  output logic [11:0]            EVT_CNT
);

  // FSM and index registers
  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_W-1:0]   r_n;
  logic [N_W-1:0]   w_n_nxt;
  logic [N_W-1:0]   r_wptr;
  logic [N_W-1:0]   w_wptr_nxt;
  logic [CH_W-1:0]  r_ch;
  logic [CH_W-1:0]  w_ch_nxt;
  logic [SMP_W-1:0] r_smp;
  logic [SMP_W-1:0] w_smp_nxt;

  // Miss / event bookkeeping
  logic              r_miss;
  logic [MISS_W-1:0] r_miss_cnt;
  logic [11:0]       r_evt_cnt;

  // Datapath helpers
  logic              w_we;
  logic [SMP_W-1:0]  w_waddr;
  logic [N_W-1:0]    w_n_clamp;
  logic [N_W-1:0]    w_wptr_inc;
  logic              w_busy;
  logic              w_vld;
  logic              w_smp_end;
  logic              w_last;
  logic              w_xfer;
  logic              w_miss;
  logic [WORD_W-1:0] w_rword;
  logic [ADC_W-1:0]  w_sample;

  assign w_n_clamp  = clamp_nsamp(NSAMP, MAX_SAMP);
  assign w_wptr_inc = r_wptr + N_W'(1);
  assign w_busy     = (r_state != IDLE);
  assign w_vld      = (r_state == SEND);
  assign w_smp_end  = ({1'b0, r_smp} == (r_n - N_W'(1)));
  assign w_last     = w_vld && (r_ch == CH_W'(NCH - 1)) && w_smp_end;
  assign w_xfer     = w_vld && dout_if.DOUT_RDY;
  assign w_miss     = L1A && w_busy;

  pipe_evt_buf #(
    .DEPTH (MAX_SAMP),
    .AW    (SMP_W)
  ) u_evt_buf (
    .CLK   (CLK),
    .WE    (w_we),
    .WADDR (w_waddr),
    .WDATA (PIPOUT),
    .RADDR (r_smp),
    .RDATA (w_rword)
  );

  // Pick the current channel's 12-bit field out of the word for the current sample
  assign w_sample = w_rword[ADC_W*r_ch +: ADC_W];

  // Next-state, buffer write control and index advance
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_wptr_nxt  = r_wptr;
    w_ch_nxt    = r_ch;
    w_smp_nxt   = r_smp;
    w_we        = 1'b0;
    w_waddr     = r_wptr[SMP_W-1:0];

    case (r_state)
      IDLE: begin
        if (L1A) begin
          w_n_nxt    = w_n_clamp;
          w_wptr_nxt = '0;
          w_ch_nxt   = '0;
          w_smp_nxt  = '0;
          if (PIPE_VLD) begin
            // The trigger word itself is sample 0
            w_we        = 1'b1;
            w_waddr     = '0;
            w_wptr_nxt  = N_W'(1);
            w_state_nxt = (w_n_clamp == N_W'(1)) ? SEND : CAPTURE;
          end else begin
            w_state_nxt = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        // Invalid cycles simply stall; there is no timeout
        if (PIPE_VLD) begin
          w_we       = 1'b1;
          w_wptr_nxt = w_wptr_inc;
          if (w_wptr_inc == r_n) begin
            w_state_nxt = SEND;
          end
        end
      end

      SEND: begin
        if (w_xfer) begin
          if (w_smp_end) begin
            w_smp_nxt = '0;
            w_ch_nxt  = r_ch + CH_W'(1);
            if (w_last) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_smp_nxt = r_smp + SMP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and index registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_wptr  <= '0;
      r_ch    <= '0;
      r_smp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_wptr  <= w_wptr_nxt;
      r_ch    <= w_ch_nxt;
      r_smp   <= w_smp_nxt;
    end
  end

  // Dropped-trigger pulse, saturating miss counter and wrapping event counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_miss     <= 1'b0;
      r_miss_cnt <= '0;
      r_evt_cnt  <= '0;
    end else begin
      r_miss <= w_miss;
      if (w_miss && (r_miss_cnt != {MISS_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + MISS_W'(1);
      end
      if (w_xfer && w_last) begin
        r_evt_cnt <= r_evt_cnt + 12'd1;
      end
    end
  end

  assign dout_if.DOUT      = w_vld ? w_sample : '0;
  assign dout_if.DOUT_CH   = r_ch;
  assign dout_if.DOUT_SMP  = r_smp;
  assign dout_if.DOUT_VLD  = w_vld;
  assign dout_if.DOUT_LAST = w_last;

  assign BUSY     = w_busy;
  assign L1A_MISS = r_miss;
  assign MISS_CNT = r_miss_cnt;
  assign EVT_CNT  = r_evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_l1a_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_l1a_readout
// Brief    : Directed self-checking bench for pipe_l1a_readout.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_l1a_readout;
  import pipe_ro_pkg::*;

  localparam int MAX_SAMP = 16;
  localparam int MISS_W   = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [WORD_W-1:0] PIPOUT = '0;
  logic              PIPE_VLD = 1'b0;
  logic              L1A = 1'b0;
  logic [N_W-1:0]    NSAMP = '0;
  logic              BUSY;
  logic              L1A_MISS;
  logic [MISS_W-1:0] MISS_CNT;
  logic [11:0]       EVT_CNT;

  int checks  = 0;
  int errors  = 0;
  int max_smp = 0;

  pipe_ro_if dif ();

  pipe_l1a_readout #(
    .MAX_SAMP (MAX_SAMP),
    .MISS_W   (MISS_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PIPOUT   (PIPOUT),
    .PIPE_VLD (PIPE_VLD),
    .L1A      (L1A),
    .NSAMP    (NSAMP),
    .dout_if  (dif),
    .BUSY     (BUSY),
    .L1A_MISS (L1A_MISS),
    .MISS_CNT (MISS_CNT),
    .EVT_CNT  (EVT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Channel c of sample s carries 16*s+c
  function automatic logic [WORD_W-1:0] mkword(input int s);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int c = 0; c < NCH; c++) w[ADC_W*c +: ADC_W] = ADC_W'(16*s + c);
    return w;
  endfunction

  // Fire L1A (with a valid word in the same cycle) and feed the capture
  task automatic start_event(input int nraw, input int n, input bit toggle, input bit miss_cap);
    int  given;
    int  cyc;
    logic v;
    L1A = 1'b1; NSAMP = N_W'(nraw); PIPE_VLD = 1'b1; PIPOUT = mkword(0);
    step();
    L1A = 1'b0;
    check("busy_after_l1a", BUSY, 1);
    given = 1;
    cyc   = 0;
    while (given < n) begin
      v = toggle ? (cyc % 2 == 1) : 1'b1;
      PIPE_VLD = v;
      PIPOUT   = v ? mkword(given) : mkword(200 + cyc);
      if (miss_cap && cyc == 0) L1A = 1'b1;
      step();
      if (miss_cap && cyc == 0) begin
        L1A = 1'b0;
        check("miss_pulse_capture", L1A_MISS, 1);
      end
      if (v) given++;
      cyc++;
    end
    PIPE_VLD = 1'b1;
    PIPOUT   = mkword(210);
    check("vld_at_send", dif.DOUT_VLD, 1);
  endtask

  // Consume one event, checking every transfer and every stall
  task automatic drain(input int n, input bit rdy_rand, input bit miss_send,
                       input bit miss_last, input int abort_at);
    int          k;
    int          budget;
    bit          stalled;
    bit          hit;
    logic        r;
    logic [20:0] prev;
    logic [20:0] cur;
    logic [20:0] exp;
    k = 0; budget = 0; stalled = 1'b0; prev = '0;
    while (k < 16*n && budget < 5000) begin
      if (abort_at >= 0 && k == abort_at) begin
        RST = 1'b1;
        dif.DOUT_RDY = 1'b1;
        step();
        RST = 1'b0;
        dif.DOUT_RDY = 1'b0;
        check("abort_vld",  dif.DOUT_VLD, 0);
        check("abort_busy", BUSY, 0);
        check("abort_evt",  EVT_CNT, 0);
        check("abort_miss", MISS_CNT, 0);
        check("abort_dout", dif.DOUT, 0);
        return;
      end
      r = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      dif.DOUT_RDY = r;
      cur = {dif.DOUT, dif.DOUT_CH, dif.DOUT_SMP, dif.DOUT_LAST};
      if (stalled) check("stall_hold", cur, prev);
      hit = 1'b0;
      if (r) begin
        exp = {ADC_W'(16*(k % n) + k / n), CH_W'(k / n), SMP_W'(k % n), 1'(k == 16*n - 1)};
        check("xfer", {dif.DOUT_VLD, cur}, {1'b1, exp});
        if (int'(dif.DOUT_SMP) > max_smp) max_smp = int'(dif.DOUT_SMP);
        if ((miss_send && k == 5) || (miss_last && k == 16*n - 1)) begin
          L1A = 1'b1;
          hit = 1'b1;
        end
        k++;
      end
      stalled = !r;
      prev    = cur;
      step();
      budget++;
      L1A = 1'b0;
      if (hit) check("miss_pulse", L1A_MISS, 1);
    end
    if (k < 16*n) check("drain_timeout", k, 16*n);
    dif.DOUT_RDY = 1'b0;
    check("busy_after_last", BUSY, 0);
    check("vld_after_last", dif.DOUT_VLD, 0);
  endtask

  // Directed sequence
  initial begin
    dif.DOUT_RDY = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    check("rst_vld",  dif.DOUT_VLD, 0);
    check("rst_last", dif.DOUT_LAST, 0);
    check("rst_dout", dif.DOUT, 0);
    check("rst_ch",   dif.DOUT_CH, 0);
    check("rst_smp",  dif.DOUT_SMP, 0);
    check("rst_busy", BUSY, 0);
    check("rst_l1am", L1A_MISS, 0);
    check("rst_miss", MISS_CNT, 0);
    check("rst_evt",  EVT_CNT, 0);

    // Ready is ignored while idle
    dif.DOUT_RDY = 1'b1;
    step(); step();
    dif.DOUT_RDY = 1'b0;
    check("idle_rdy_busy", BUSY, 0);
    check("idle_rdy_evt",  EVT_CNT, 0);

    // Basic four-sample event
    start_event(4, 4, 1'b0, 1'b0);
    drain(4, 1'b0, 1'b0, 1'b0, -1);
    check("evt_after_n4", EVT_CNT, 1);

    // NSAMP clamp: 0 and 20 both give a full 16-sample event
    max_smp = 0;
    start_event(0, 16, 1'b0, 1'b0);
    drain(16, 1'b0, 1'b0, 1'b0, -1);
    check("max_smp_n0", max_smp, 15);
    max_smp = 0;
    start_event(20, 16, 1'b0, 1'b0);
    drain(16, 1'b0, 1'b0, 1'b0, -1);
    check("max_smp_n20", max_smp, 15);
    check("evt_after_clamp", EVT_CNT, 3);

    // Gapped capture and random back-pressure
    start_event(5, 5, 1'b1, 1'b0);
    drain(5, 1'b1, 1'b0, 1'b0, -1);
    check("evt_after_gapped", EVT_CNT, 4);

    // Triggers during capture, during send and on the last transfer
    start_event(4, 4, 1'b0, 1'b1);
    drain(4, 1'b0, 1'b1, 1'b1, -1);
    check("miss_cnt_3", MISS_CNT, 3);
    check("evt_after_miss", EVT_CNT, 5);

    // Saturation: 300 dropped triggers while stalled in send
    start_event(16, 16, 1'b0, 1'b0);
    L1A = 1'b1;
    repeat (300) step();
    L1A = 1'b0;
    check("miss_cnt_sat", MISS_CNT, 255);
    check("vld_while_stalled", dif.DOUT_VLD, 1);
    drain(16, 1'b0, 1'b0, 1'b0, -1);
    check("evt_after_sat", EVT_CNT, 6);

    // Reset mid-send, then a clean event
    start_event(4, 4, 1'b0, 1'b0);
    drain(4, 1'b0, 1'b0, 1'b0, 10);
    start_event(3, 3, 1'b0, 1'b0);
    drain(3, 1'b0, 1'b0, 1'b0, -1);
    check("evt_after_abort", EVT_CNT, 1);

    // Single-sample event straight from idle to send
    max_smp = 0;
    start_event(1, 1, 1'b0, 1'b0);
    drain(1, 1'b0, 1'b0, 1'b0, -1);
    check("max_smp_n1", max_smp, 0);
    check("evt_after_n1", EVT_CNT, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_l1a_readout.md
# pipe_l1a_readout

Read-side consumer of the per-group DAQ pipeline. It watches one group's 192-bit pipeline output word stream (16 channels × 12-bit ADC samples, one word per pipeline read). On an L1A it captures NSAMP consecutive valid words into a local event buffer, then streams them out one 12-bit sample per transfer over a valid/ready handshake, channel-major. One instance sits after each group's pipeline output register and feeds the downstream DAQ formatter.

## Interface
Parameters:
- MAX_SAMP, 16, event buffer depth in pipeline words; legal NSAMP range is 1..MAX_SAMP
- MISS_W, 8, width of the saturating missed-L1A counter

Ports:
- CLK  in  1  readout clock, same domain as the pipeline read clock
- RST  in  1  synchronous, active-high reset
- PIPOUT  in  192  pipeline output word; channel c occupies bits [12c+11:12c]
- PIPE_VLD  in  1  PIPOUT holds a new pipeline sample this cycle
- L1A  in  1  single-cycle trigger accept
- NSAMP  in  5  samples per event; sampled only on an accepted L1A; 0 or >MAX_SAMP is treated as MAX_SAMP
- DOUT  out  12  ADC sample; 0 when DOUT_VLD=0
- DOUT_CH  out  4  channel index of DOUT
- DOUT_SMP  out  4  sample index of DOUT
- DOUT_VLD  out  1  DOUT valid
- DOUT_LAST  out  1  high with the final transfer of an event
- DOUT_RDY  in  1  downstream accepts
- BUSY  out  1  high in CAPTURE or SEND
- L1A_MISS  out  1  one-cycle pulse, L1A arrived while BUSY
- MISS_CNT  out  MISS_W  missed L1As, saturating
- EVT_CNT  out  12  completed events, wraps 4095→0

## Operation
- States: IDLE, CAPTURE, SEND.
- IDLE: L1A latches n (NSAMP after clamping), clears wptr. If PIPE_VLD is also high, PIPOUT is written as sample 0 and wptr=1. If n=1 and a word was written, go to SEND; otherwise go to CAPTURE.
- CAPTURE: each PIPE_VLD cycle writes PIPOUT to buf[wptr] and increments wptr. The write that makes wptr equal to n goes to SEND. Cycles with PIPE_VLD=0 stall the capture; no timeout.
- SEND: DOUT_VLD=1, DOUT=buf[smp][12ch+11:12ch]. Order is ch 0..15 outer, smp 0..n-1 inner.
  - On a VLD&RDY transfer: if smp=n-1, then smp←0 and ch←ch+1; otherwise smp←smp+1.
  - DOUT_LAST=1 when ch=15 and smp=n-1. Its transfer returns the FSM to IDLE and increments EVT_CNT.
  - Each event produces 16·n transfers.
- Handshake: while VLD=1 and RDY=0, DOUT, DOUT_CH, DOUT_SMP and DOUT_LAST hold stable. RDY is ignored outside SEND.
- L1A while BUSY, including the cycle of the LAST transfer:
  - the L1A is dropped;
  - L1A_MISS pulses the next cycle;
  - MISS_CNT increments, holding at 2^MISS_W−1.
- An L1A accepted in IDLE cannot coincide with a LAST transfer, because LAST occurs only in SEND.
- Reset:
  - Next cycle: IDLE, ch=smp=wptr=0, DOUT_VLD=0, DOUT_LAST=0, BUSY=0, L1A_MISS=0, MISS_CNT=0, EVT_CNT=0, DOUT=0.
  - Buffer contents are not cleared.
  - Reset mid-CAPTURE or mid-SEND abandons the event without LAST and without an EVT_CNT increment.

## Timing
- All state, indices and counters are registered on posedge CLK. DOUT is muxed from the registered buffer and registered indices, with no extra latency.
- With PIPE_VLD held high and L1A at cycle t: samples are captured at t..t+n−1, and BUSY=1 from t+1.
  - First DOUT_VLD at t+n.
  - With RDY held high, LAST is at t+n+16n−1 and BUSY falls the following cycle.
- Minimum L1A spacing without a miss: 16n+n cycles, assuming RDY continuously high.
- A buffer write in cycle k is readable in SEND from cycle k+1.

## Structure
- Shared package `pipe_ro_pkg`:
  - NCH=16, ADC_W=12, WORD_W=192;
  - state enum {IDLE, CAPTURE, SEND};
  - function for the NSAMP clamp.
- Sub-module `pipe_evt_buf`: MAX_SAMP×192 register array with one synchronous write port and one asynchronous read port addressed by smp.
- Top level: FSM, the 12-bit channel mux, and the counters.

## Test plan
- RST; L1A with NSAMP=4, PIPE_VLD=1, PIPOUT[12c+11:12c]=16·s+c → 64 transfers, with DOUT=16·smp+ch in channel-major order, LAST only on ch=15,smp=3, and EVT_CNT=1.
- NSAMP=0 and NSAMP=20 → each event yields 256 transfers, with DOUT_SMP reaching 15.
- PIPE_VLD toggling 1/0 during CAPTURE, with DOUT_RDY randomly deasserted in SEND → captured words are only those with VLD=1, and outputs are stable during every stall.
- L1A issued during CAPTURE, during SEND, and on the LAST cycle → 3 L1A_MISS pulses, MISS_CNT=3, and the first event is unaffected. 300 busy L1As → MISS_CNT=255.
- RST asserted mid-SEND at transfer 10 → next cycle DOUT_VLD=0, BUSY=0, EVT_CNT=0. A subsequent L1A produces a complete correct event.
- NSAMP=1 with L1A and PIPE_VLD in the same cycle → SEND next cycle, 16 transfers with smp=0, LAST on ch=15.
